// File: rtl/pong_video_pkg.sv
// pong_video_pkg: shared video constants and types for the pong video pipeline.
//   - 720p raster timing defaults (active size, porches, sync widths)
//   - rgb_t / pixel_t colour types and named colour constants
//   - counter width and the largest raster total that width can hold
package pong_video_pkg;

    localparam int unsigned H_RES  = 1280;
    localparam int unsigned H_FP   = 110;
    localparam int unsigned H_SYNC = 40;
    localparam int unsigned H_BP   = 220;
    localparam int unsigned V_RES  = 720;
    localparam int unsigned V_FP   = 5;
    localparam int unsigned V_SYNC = 5;
    localparam int unsigned V_BP   = 20;

    // Raster counters are 11 bits; hpos/vpos add a zero sign bit on top.
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2047;

    typedef logic [23:0] rgb_t;         // {R,G,B}
    typedef logic [2:0][7:0] pixel_t;   // [2]=R, [1]=G, [0]=B

    localparam rgb_t COLOR_BLACK = 24'h000000;
    localparam rgb_t COLOR_WHITE = 24'hFFFFFF;
    localparam rgb_t COLOR_RED   = 24'hFF0000;
    localparam rgb_t COLOR_GREEN = 24'h00FF00;
    localparam rgb_t COLOR_BLUE  = 24'h0000FF;

    function automatic rgb_t to_rgb(input pixel_t p);
        return {p[2], p[1], p[0]};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters and timing decode.
//   pixel_clk, rst : clock, synchronous active-high reset
//   hcnt, vcnt     : registered raster position
//   fsync          : one-cycle pulse at (0, VRES), start of vertical blank
//   de, hs, vs     : active / hsync / vsync decode of the current position
//   frame_cnt      : completed frames, wraps
module video_timing_gen
    import pong_video_pkg::*;
#(
    parameter int unsigned HRES  = H_RES,
    parameter int unsigned HFP   = H_FP,
    parameter int unsigned HSYNC = H_SYNC,
    parameter int unsigned HBP   = H_BP,
    parameter int unsigned VRES  = V_RES,
    parameter int unsigned VFP   = V_FP,
    parameter int unsigned VSYNC = V_SYNC,
    parameter int unsigned VBP   = V_BP
) (
    input  logic             pixel_clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             fsync,
    output logic             de,
    output logic             hs,
    output logic             vs,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned HTOTAL = HRES + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VRES + VFP + VSYNC + VBP;

    if (HTOTAL > MAX_TOTAL) begin : g_htotal_chk
        $error("video_timing_gen: HTOTAL %0d exceeds %0d", HTOTAL, MAX_TOTAL);
    end
    if (VTOTAL > MAX_TOTAL) begin : g_vtotal_chk
        $error("video_timing_gen: VTOTAL %0d exceeds %0d", VTOTAL, MAX_TOTAL);
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(HRES);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(VRES);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(HRES + HFP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(HRES + HFP + HSYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(VRES + VFP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(VRES + VFP + VSYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap      = (hcnt_q == H_LAST);
        v_wrap      = (vcnt_q == V_LAST);
        hcnt_d      = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
            if (v_wrap) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign frame_cnt = frame_cnt_q;
    // Decoded from the registered counters, so sprites see it for exactly one cycle.
    assign fsync     = (hcnt_q == '0) && (vcnt_q == V_ACT);
    assign de        = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hs        = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    assign vs        = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

endmodule

// File: rtl/video_timing_compositor.sv
// video_timing_compositor: raster timing source and sprite compositor.
//   pixel_clk, rst        : clock, synchronous active-high reset
//   hpos, vpos, fsync     : raster position and frame pulse to the sprites
//   sN_active, sN_pixel   : sprite coverage and colour (s0 highest priority)
//   vid_rgb/hsync/vsync/de: registered stream to the encoder, one cycle behind hpos/vpos
//   frame_cnt             : completed frames, wraps
module video_timing_compositor
    import pong_video_pkg::*;
#(
    parameter int unsigned HRES     = H_RES,
    parameter int unsigned HFP      = H_FP,
    parameter int unsigned HSYNC    = H_SYNC,
    parameter int unsigned HBP      = H_BP,
    parameter int unsigned VRES     = V_RES,
    parameter int unsigned VFP      = V_FP,
    parameter int unsigned VSYNC    = V_SYNC,
    parameter int unsigned VBP      = V_BP,
    parameter bit          SYNC_POL = 1'b1,
    parameter rgb_t        BG_COLOR = COLOR_BLACK
) (
    input  logic               pixel_clk,
    input  logic               rst,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    input  logic               s0_active,
    input  logic [2:0][7:0]    s0_pixel,
    input  logic               s1_active,
    input  logic [2:0][7:0]    s1_pixel,
    input  logic               s2_active,
    input  logic [2:0][7:0]    s2_pixel,
    output logic [23:0]        vid_rgb,
    output logic               vid_hsync,
    output logic               vid_vsync,
    output logic               vid_de,
    output logic [15:0]        frame_cnt
);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             de, hs, vs;
    rgb_t             mix_rgb;

    video_timing_gen #(
        .HRES  (HRES),
        .HFP   (HFP),
        .HSYNC (HSYNC),
        .HBP   (HBP),
        .VRES  (VRES),
        .VFP   (VFP),
        .VSYNC (VSYNC),
        .VBP   (VBP)
    ) u_timing (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .fsync     (fsync),
        .de        (de),
        .hs        (hs),
        .vs        (vs),
        .frame_cnt (frame_cnt)
    );

    assign hpos = {1'b0, hcnt};
    assign vpos = {1'b0, vcnt};

    // Sprite inputs are combinational from this cycle's hpos/vpos; blanking forces black.
    always_comb begin
        mix_rgb = '0;
        if (de) begin
            if (s0_active) begin
                mix_rgb = to_rgb(s0_pixel);
            end else if (s1_active) begin
                mix_rgb = to_rgb(s1_pixel);
            end else if (s2_active) begin
                mix_rgb = to_rgb(s2_pixel);
            end else begin
                mix_rgb = BG_COLOR;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            vid_rgb   <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= ~SYNC_POL;
            vid_vsync <= ~SYNC_POL;
        end else begin
            vid_rgb   <= mix_rgb;
            vid_de    <= de;
            vid_hsync <= hs ? SYNC_POL : ~SYNC_POL;
            vid_vsync <= vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_video_timing_compositor.sv
// Directed bench for video_timing_compositor on a shrunken raster (25 x 14) so
// whole lines and frames fit in a short run.
module tb_video_timing_compositor;

    localparam int HR = 16, HF = 2, HS = 3, HB = 4, HT = HR + HF + HS + HB;
    localparam int VR = 8, VF = 1, VS = 2, VB = 3, VT = VR + VF + VS + VB;
    localparam logic [23:0] BG = 24'h123456;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] hpos, vpos;
    logic               fsync;
    logic               s0_active = 1'b0, s1_active = 1'b0, s2_active = 1'b0;
    logic [2:0][7:0]    s0_pixel = '0, s1_pixel = '0, s2_pixel = '0;
    logic [23:0]        vid_rgb;
    logic               vid_hsync, vid_vsync, vid_de;
    logic [15:0]        frame_cnt;

    int errors = 0;
    int checks = 0;
    int exp_h = 0, exp_v = 0, prev_h = 0, prev_v = 0;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_compositor #(
        .HRES     (HR),
        .HFP      (HF),
        .HSYNC    (HS),
        .HBP      (HB),
        .VRES     (VR),
        .VFP      (VF),
        .VSYNC    (VS),
        .VBP      (VB),
        .SYNC_POL (1'b1),
        .BG_COLOR (BG)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hpos      (hpos),
        .vpos      (vpos),
        .fsync     (fsync),
        .s0_active (s0_active),
        .s0_pixel  (s0_pixel),
        .s1_active (s1_active),
        .s1_pixel  (s1_pixel),
        .s2_active (s2_active),
        .s2_pixel  (s2_pixel),
        .vid_rgb   (vid_rgb),
        .vid_hsync (vid_hsync),
        .vid_vsync (vid_vsync),
        .vid_de    (vid_de),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; sample 1 time unit after the edge and advance the expected raster.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
        prev_h = exp_h;
        prev_v = exp_v;
        if (rst) begin
            exp_h = 0;
            exp_v = 0;
        end else if (exp_h == HT - 1) begin
            exp_h = 0;
            exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
        end else begin
            exp_h = exp_h + 1;
        end
    endtask

    initial begin
        int de_n, hs_n, rise_h, bad;
        int vs_n, vs_h, vs_v, fs_n, fs_bad, mism;
        logic de_e, hs_e, vs_e;

        // Reset state
        repeat (3) tick();
        check("rst_hpos", 32'(hpos), 32'd0);
        check("rst_vpos", 32'(vpos), 32'd0);
        check("rst_de", 32'(vid_de), 32'd0);
        check("rst_rgb", 32'(vid_rgb), 32'd0);
        check("rst_hsync", 32'(vid_hsync), 32'd0);
        check("rst_vsync", 32'(vid_vsync), 32'd0);
        check("rst_fsync", 32'(fsync), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // Release; first active cycle, s0 beats s1
        rst = 1'b0;
        s0_active = 1'b1; s0_pixel = 24'hFF0000;
        s1_active = 1'b1; s1_pixel = 24'h00FF00;
        check("first_hpos", 32'(hpos), 32'd0);
        tick();
        check("first_de", 32'(vid_de), 32'd1);
        check("first_hsync", 32'(vid_hsync), 32'd0);
        check("first_vsync", 32'(vid_vsync), 32'd0);
        check("prio_s0_over_s1", 32'(vid_rgb), 32'hFF0000);
        check("hpos_step", 32'(hpos), 32'd1);

        s0_active = 1'b0; s1_active = 1'b0;
        s2_active = 1'b1; s2_pixel = 24'h0000FF;
        tick();
        check("prio_s2_only", 32'(vid_rgb), 32'h0000FF);

        s1_active = 1'b1;
        tick();
        check("prio_s1_over_s2", 32'(vid_rgb), 32'h00FF00);

        s1_active = 1'b0; s2_active = 1'b0;
        tick();
        check("prio_none_bg", 32'(vid_rgb), 32'(BG));

        // Line timing with s0 tied high
        s0_active = 1'b1;
        while (exp_h != 0) tick();
        check("line1_frame_cnt", 32'(frame_cnt), 32'd0);
        de_n = 0; hs_n = 0; rise_h = -1; bad = 0;
        for (int i = 0; i < HT; i++) begin
            tick();
            if (vid_de) de_n++;
            if (vid_hsync) begin
                hs_n++;
                if (rise_h < 0) rise_h = exp_h;
            end
            if (!vid_de && vid_rgb != 24'h0) bad++;
            if (vid_de && vid_rgb != 24'hFF0000) bad++;
        end
        check("line_de_cycles", 32'(de_n), 32'(HR));
        check("line_hsync_cycles", 32'(hs_n), 32'(HS));
        check("line_hsync_rise", 32'(rise_h), 32'(HR + HF + 1));
        check("line_blank_rgb", 32'(bad), 32'd0);
        check("line_wrap_vpos", 32'(vpos), 32'd2);

        // Rest of the frame: vsync, fsync, blanking, frame counter
        vs_n = 0; vs_h = -1; vs_v = -1; fs_n = 0; fs_bad = 0; mism = 0;
        for (int i = 0; i < (VT - 2) * HT; i++) begin
            tick();
            if (fsync) begin
                fs_n++;
                if (!(exp_h == 0 && exp_v == VR)) fs_bad++;
            end
            if (vid_vsync) begin
                vs_n++;
                if (vs_h < 0) begin
                    vs_h = exp_h;
                    vs_v = exp_v;
                end
            end
            de_e = (prev_h < HR) && (prev_v < VR);
            hs_e = (prev_h >= HR + HF) && (prev_h < HR + HF + HS);
            vs_e = (prev_v >= VR + VF) && (prev_v < VR + VF + VS);
            if (vid_de !== de_e || vid_hsync !== hs_e || vid_vsync !== vs_e) mism++;
            if (vid_rgb !== (de_e ? 24'hFF0000 : 24'h0)) mism++;
        end
        check("frame_vsync_cycles", 32'(vs_n), 32'(VS * HT));
        check("frame_vsync_rise_h", 32'(vs_h), 32'd1);
        check("frame_vsync_rise_v", 32'(vs_v), 32'(VR + VF));
        check("frame_fsync_count", 32'(fs_n), 32'd1);
        check("frame_fsync_pos", 32'(fs_bad), 32'd0);
        check("frame_stream", 32'(mism), 32'd0);
        check("frame_cnt_one", 32'(frame_cnt), 32'd1);
        check("frame_wrap_hpos", 32'(hpos), 32'd0);
        check("frame_wrap_vpos", 32'(vpos), 32'd0);

        // Reset mid-frame while inside hsync
        while (!(exp_v == 3 && exp_h == HR + HF + 2)) tick();
        check("pre_reset_hsync", 32'(vid_hsync), 32'd1);
        check("pre_reset_vpos", 32'(vpos), 32'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_hpos", 32'(hpos), 32'd0);
        check("mid_rst_vpos", 32'(vpos), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_de", 32'(vid_de), 32'd0);
        check("mid_rst_rgb", 32'(vid_rgb), 32'd0);
        check("mid_rst_hsync", 32'(vid_hsync), 32'd0);
        check("mid_rst_vsync", 32'(vid_vsync), 32'd0);
        check("mid_rst_fsync", 32'(fsync), 32'd0);
        rst = 1'b0;
        tick();
        check("resume_hpos", 32'(hpos), 32'd1);
        check("resume_de", 32'(vid_de), 32'd1);
        check("resume_rgb", 32'(vid_rgb), 32'hFF0000);
        repeat (HT - 1) tick();
        check("resume_line_hpos", 32'(hpos), 32'd0);
        check("resume_line_vpos", 32'(vpos), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
